// File: rtl/muller_c_monitor_pkg.sv
// muller_c_monitor_pkg.sv: shared FSM state and violation encodings for the Muller C-element monitor.
package muller_c_pkg;
    typedef enum logic [1:0] {
        ST_IDLE_LO  = 2'b00,
        ST_ARMED_HI = 2'b01,
        ST_IDLE_HI  = 2'b10,
        ST_ARMED_LO = 2'b11
    } state_t;
    typedef enum logic [1:0] {
        VC_NONE    = 2'b00,
        VC_RISE    = 2'b01,
        VC_FALL    = 2'b10,
        VC_TIMEOUT = 2'b11
    } viol_t;
    function automatic state_t seed_state(input logic c);
        return c ? ST_IDLE_HI : ST_IDLE_LO;
    endfunction
endpackage

// File: rtl/muller_c_monitor_if.sv
// muller_c_monitor_if.sv: C-element pins in, counters and violation readout out.
interface muller_c_monitor_if import muller_c_pkg::*; #(parameter int CNT_W = 16);
    logic             a_async;
    logic             b_async;
    logic             c_async;
    logic             clr;
    logic             c_sync;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    state_t           state;
    logic             violation;
    viol_t            viol_code;
    logic             timeout;
    modport master (
        output a_async, b_async, c_async, clr,
        input  c_sync, rise_cnt, fall_cnt, state, violation, viol_code, timeout
    );
    modport slave (
        input  a_async, b_async, c_async, clr,
        output c_sync, rise_cnt, fall_cnt, state, violation, viol_code, timeout
    );
endinterface

// File: rtl/muller_c_monitor_sync.sv
// muller_c_monitor_sync.sv: SYNC_STAGES-deep flop chain bringing one async pin into the clk domain.
module muller_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_ff;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ff <= '0;
        else        r_ff <= {r_ff[SYNC_STAGES-2:0], i_d};
    end
    assign o_q = r_ff[SYNC_STAGES-1];
endmodule

// File: rtl/muller_c_monitor.sv
// muller_c_monitor.sv: counts C transitions and tracks the four-phase protocol, flagging sticky violations.
// Defining MULLER_MON_TIMEOUT_EN adds an armed-state response timeout (viol_code 11).
module muller_c_monitor import muller_c_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input logic                clk,
    input logic                rst_n,
    muller_c_monitor_if.slave  bus
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("muller_c_monitor: illegal SYNC_STAGES or TIMEOUT_CYC");
    end

    logic             w_a_s, w_b_s, w_c_s;
    logic             r_a_q, r_b_q, r_c_q;
    logic             w_rise, w_fall, w_hi_ok, w_lo_ok;
    logic             w_to_hit, w_vset, r_viol;
    state_t           r_state, w_nxt;
    viol_t            w_code, r_code;
    logic [CNT_W-1:0] r_rise, r_fall;

    muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst_n(rst_n), .i_d(bus.a_async), .o_q(w_a_s));
    muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst_n(rst_n), .i_d(bus.b_async), .o_q(w_b_s));
    muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (.clk(clk), .rst_n(rst_n), .i_d(bus.c_async), .o_q(w_c_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {r_a_q, r_b_q, r_c_q} <= '0;
        else        {r_a_q, r_b_q, r_c_q} <= {w_a_s, w_b_s, w_c_s};
    end

    assign w_rise  = w_c_s & ~r_c_q;
    assign w_fall  = ~w_c_s & r_c_q;
    // consensus holds if either this or the previous sample agrees, absorbing one cycle of sync skew
    assign w_hi_ok = (w_a_s & w_b_s) | (r_a_q & r_b_q);
    assign w_lo_ok = (~w_a_s & ~w_b_s) | (~r_a_q & ~r_b_q);

    always_comb begin
        w_nxt  = r_state;
        w_vset = 1'b0;
        w_code = VC_NONE;
        case (r_state)
            ST_IDLE_LO: begin
                w_nxt  = w_rise ? ST_IDLE_HI : w_hi_ok ? ST_ARMED_HI : ST_IDLE_LO;
                w_vset = w_rise & ~w_hi_ok;
                w_code = VC_RISE;
            end
            ST_ARMED_HI: w_nxt = w_rise ? ST_IDLE_HI : w_hi_ok ? ST_ARMED_HI : ST_IDLE_LO;
            ST_IDLE_HI: begin
                w_nxt  = w_fall ? ST_IDLE_LO : w_lo_ok ? ST_ARMED_LO : ST_IDLE_HI;
                w_vset = w_fall & ~w_lo_ok;
                w_code = VC_FALL;
            end
            default: w_nxt = w_fall ? ST_IDLE_LO : w_lo_ok ? ST_ARMED_LO : ST_IDLE_HI;
        endcase
        if (w_to_hit && !w_vset) begin
            w_vset = 1'b1;
            w_code = VC_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE_LO;
            r_rise  <= '0;
            r_fall  <= '0;
            r_viol  <= 1'b0;
            r_code  <= VC_NONE;
        end else if (bus.clr) begin
            r_state <= seed_state(w_c_s);
            r_rise  <= '0;
            r_fall  <= '0;
            r_viol  <= 1'b0;
            r_code  <= VC_NONE;
        end else begin
            r_state <= w_nxt;
            r_rise  <= r_rise + CNT_W'(w_rise & ~&r_rise);
            r_fall  <= r_fall + CNT_W'(w_fall & ~&r_fall);
            r_viol  <= r_viol | w_vset;
            if (w_vset && !r_viol) r_code <= w_code;
        end
    end

`ifdef MULLER_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_armed, r_timeout;
    assign w_armed  = (r_state == ST_ARMED_HI) || (r_state == ST_ARMED_LO);
    assign w_to_hit = w_armed && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    // counter parks at its limit so the armed state can persist indefinitely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= (w_armed && !bus.clr) ? r_to_cnt + TW'(!w_to_hit) : '0;
            r_timeout <= !bus.clr && (r_timeout || w_to_hit);
        end
    end
    assign bus.timeout = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.c_sync    = w_c_s;
    assign bus.rise_cnt  = r_rise;
    assign bus.fall_cnt  = r_fall;
    assign bus.state     = r_state;
    assign bus.violation = r_viol;
    assign bus.viol_code = r_code;
endmodule

// File: tb/tb_muller_c_monitor.sv
// tb_muller_c_monitor.sv: directed and randomized checks of muller_c_monitor against a cycle model.
module tb_muller_c_monitor;
    localparam int SS   = 2;
    localparam int CW   = 4;
    localparam int TO   = 64;
    localparam int MAXC = (1 << CW) - 1;
`ifdef MULLER_MON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    muller_c_monitor_if #(.CNT_W(CW)) bus ();
    muller_c_monitor #(.SYNC_STAGES(SS), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    bit m_as, m_bs, m_cs, m_aq, m_bq, m_cq, m_viol, m_to;
    bit qa[$], qb[$], qc[$];
    int m_st, m_rise, m_fall, m_code, m_armed;

    task automatic model_reset();
        {m_as, m_bs, m_cs, m_aq, m_bq, m_cq, m_viol, m_to} = '0;
        m_st = 0; m_rise = 0; m_fall = 0; m_code = 0; m_armed = 0;
        qa.delete(); qb.delete(); qc.delete();
        repeat (SS - 1) begin qa.push_back(1'b0); qb.push_back(1'b0); qc.push_back(1'b0); end
    endtask

    task automatic model_step();
        bit rise, fall, hi_ok, lo_ok, vset;
        int nst, vcode;
        rise  = m_cs && !m_cq;
        fall  = !m_cs && m_cq;
        hi_ok = (m_as && m_bs) || (m_aq && m_bq);
        lo_ok = (!m_as && !m_bs) || (!m_aq && !m_bq);
        if (bus.clr) begin
            m_rise = 0; m_fall = 0; m_viol = 0; m_code = 0; m_to = 0; m_armed = 0;
            m_st = m_cs ? 2 : 0;
        end else begin
            vset = 0; vcode = 0;
            if (m_st < 2) begin
                if (rise) begin nst = 2; if (m_st == 0 && !hi_ok) begin vset = 1; vcode = 1; end end
                else nst = hi_ok ? 1 : 0;
            end else begin
                if (fall) begin nst = 0; if (m_st == 2 && !lo_ok) begin vset = 1; vcode = 2; end end
                else nst = lo_ok ? 3 : 2;
            end
            m_armed = (m_st == 1 || m_st == 3) ? m_armed + 1 : 0;
            if (TO_EN && m_armed >= TO) begin m_to = 1; if (!vset) begin vset = 1; vcode = 3; end end
            if (vset && !m_viol) m_code = vcode;
            if (vset) m_viol = 1;
            if (rise && m_rise < MAXC) m_rise++;
            if (fall && m_fall < MAXC) m_fall++;
            m_st = nst;
        end
        m_aq = m_as; m_bq = m_bs; m_cq = m_cs;
        qa.push_back(bus.a_async); qb.push_back(bus.b_async); qc.push_back(bus.c_async);
        m_as = qa.pop_front(); m_bs = qb.pop_front(); m_cs = qc.pop_front();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_pins(input bit a, input bit b, input bit c);
        bus.a_async = a; bus.b_async = b; bus.c_async = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.clr = 1'b0;
        set_pins(0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic legal_cycles(input int n);
        repeat (n) begin
            set_pins(1, 1, 0); tick(3);
            set_pins(1, 1, 1); tick(4);
            set_pins(0, 0, 1); tick(3);
            set_pins(0, 0, 0); tick(4);
        end
    endtask

    task automatic test_reset();
        set_pins(1, 1, 1);
        bus.clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.state); end
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL reset_rise got=%0d want=0", bus.rise_cnt); end
        total++; if (bus.fall_cnt !== 4'd0) begin bad++; $display("FAIL reset_fall got=%0d want=0", bus.fall_cnt); end
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL reset_viol got=%0b want=0", bus.violation); end
        total++; if (bus.viol_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", bus.viol_code); end
        total++; if (bus.c_sync !== 1'b0) begin bad++; $display("FAIL reset_csync got=%0b want=0", bus.c_sync); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", bus.timeout); end
    endtask

    task automatic test_legal_cycle();
        int seq[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        bit ok;
        do_reset();
        seq.push_back(int'(bus.state));
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: set_pins(1, 1, 0);
                1: set_pins(1, 1, 1);
                2: set_pins(0, 0, 1);
                default: set_pins(0, 0, 0);
            endcase
            repeat (6) begin
                tick(1);
                if (int'(bus.state) != seq[$]) seq.push_back(int'(bus.state));
            end
        end
        ok = (seq.size() == 5);
        for (int i = 0; i < 5 && ok; i++) ok = (seq[i] == exp_seq[i]);
        total++; if (!ok) begin bad++; $display("FAIL legal_seq got_len=%0d want=00,01,10,11,00", seq.size()); end
        total++; if (bus.rise_cnt !== 4'd1) begin bad++; $display("FAIL legal_rise got=%0d want=1", bus.rise_cnt); end
        total++; if (bus.fall_cnt !== 4'd1) begin bad++; $display("FAIL legal_fall got=%0d want=1", bus.fall_cnt); end
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL legal_viol got=%0b want=0", bus.violation); end
    endtask

    task automatic test_premature_rise();
        do_reset();
        set_pins(1, 0, 1); tick(6);
        total++; if (bus.violation !== 1'b1) begin bad++; $display("FAIL prem_viol got=%0b want=1", bus.violation); end
        total++; if (bus.viol_code !== 2'd1) begin bad++; $display("FAIL prem_code got=%0d want=1", bus.viol_code); end
        total++; if (bus.rise_cnt !== 4'd1) begin bad++; $display("FAIL prem_rise got=%0d want=1", bus.rise_cnt); end
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL prem_state got=%0d want=2", bus.state); end
        set_pins(1, 0, 0); tick(6);
        total++; if (bus.viol_code !== 2'd1) begin bad++; $display("FAIL prem_first_code got=%0d want=1", bus.viol_code); end
        total++; if (bus.fall_cnt !== 4'd1) begin bad++; $display("FAIL prem_fall got=%0d want=1", bus.fall_cnt); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL prem_state2 got=%0d want=0", bus.state); end
        bus.clr = 1'b1; tick(1); bus.clr = 1'b0;
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL clr_viol got=%0b want=0", bus.violation); end
        total++; if (bus.viol_code !== 2'd0) begin bad++; $display("FAIL clr_code got=%0d want=0", bus.viol_code); end
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL clr_rise got=%0d want=0", bus.rise_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        legal_cycles(20);
        total++; if (bus.rise_cnt !== 4'd15) begin bad++; $display("FAIL sat_rise got=%0d want=15", bus.rise_cnt); end
        total++; if (bus.fall_cnt !== 4'd15) begin bad++; $display("FAIL sat_fall got=%0d want=15", bus.fall_cnt); end
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL sat_viol got=%0b want=0", bus.violation); end
    endtask

    task automatic test_clr_collision();
        do_reset();
        set_pins(1, 1, 0); tick(3);
        set_pins(1, 1, 1); tick(2);
        bus.clr = 1'b1; tick(1); bus.clr = 1'b0;
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL coll_rise got=%0d want=0", bus.rise_cnt); end
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL coll_viol got=%0b want=0", bus.violation); end
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL coll_state got=%0d want=2", bus.state); end
        tick(3);
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL coll_rise_later got=%0d want=0", bus.rise_cnt); end
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL coll_state_later got=%0d want=2", bus.state); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        legal_cycles(3);
        set_pins(1, 1, 0); tick(3);
        total++; if (bus.state !== 2'd1 || bus.rise_cnt !== 4'd3) begin bad++; $display("FAIL mid_pre state=%0d rise=%0d want=1,3", bus.state, bus.rise_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_rise got=%0d want=0", bus.rise_cnt); end
        total++; if (bus.fall_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_fall got=%0d want=0", bus.fall_cnt); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d want=0", bus.state); end
        set_pins(1, 1, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(SS);
        total++; if (bus.c_sync !== 1'b1) begin bad++; $display("FAIL mid_csync got=%0b want=1", bus.c_sync); end
        total++; if (bus.rise_cnt !== 4'd0) begin bad++; $display("FAIL mid_rise_early got=%0d want=0", bus.rise_cnt); end
        tick(1);
        total++; if (bus.rise_cnt !== 4'd1) begin bad++; $display("FAIL mid_rise got=%0d want=1", bus.rise_cnt); end
        total++; if (bus.violation !== 1'b0) begin bad++; $display("FAIL mid_viol got=%0b want=0", bus.violation); end
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL mid_state got=%0d want=2", bus.state); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0: bus.a_async = ~bus.a_async;
                    1: bus.b_async = ~bus.b_async;
                    default: bus.c_async = ~bus.c_async;
                endcase
            end
            bus.clr = ($urandom_range(39) == 0);
            tick(1);
            total++; if (bus.state !== 2'(m_st)) begin bad++; $display("FAIL rand_state cyc=%0d got=%0d want=%0d", cyc, bus.state, m_st); end
            total++; if (bus.rise_cnt !== CW'(m_rise)) begin bad++; $display("FAIL rand_rise cyc=%0d got=%0d want=%0d", cyc, bus.rise_cnt, m_rise); end
            total++; if (bus.fall_cnt !== CW'(m_fall)) begin bad++; $display("FAIL rand_fall cyc=%0d got=%0d want=%0d", cyc, bus.fall_cnt, m_fall); end
            total++; if (bus.violation !== m_viol) begin bad++; $display("FAIL rand_viol cyc=%0d got=%0b want=%0b", cyc, bus.violation, m_viol); end
            total++; if (bus.viol_code !== 2'(m_code)) begin bad++; $display("FAIL rand_code cyc=%0d got=%0d want=%0d", cyc, bus.viol_code, m_code); end
            total++; if (bus.c_sync !== m_cs) begin bad++; $display("FAIL rand_csync cyc=%0d got=%0b want=%0b", cyc, bus.c_sync, m_cs); end
            total++; if (bus.timeout !== m_to) begin bad++; $display("FAIL rand_timeout cyc=%0d got=%0b want=%0b", cyc, bus.timeout, m_to); end
        end
        bus.clr = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        set_pins(1, 1, 0);
        tick(66);
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%0b want=0", bus.timeout); end
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL to_armed got=%0d want=1", bus.state); end
        tick(1);
        total++; if (bus.timeout !== TO_EN) begin bad++; $display("FAIL to_flag got=%0b want=%0b", bus.timeout, TO_EN); end
        total++; if (bus.viol_code !== (TO_EN ? 2'd3 : 2'd0)) begin bad++; $display("FAIL to_code got=%0d want=%0d", bus.viol_code, TO_EN ? 3 : 0); end
        total++; if (bus.violation !== TO_EN) begin bad++; $display("FAIL to_viol got=%0b want=%0b", bus.violation, TO_EN); end
        tick(3);
        total++; if (bus.state !== 2'd1 || bus.timeout !== m_to) begin bad++; $display("FAIL to_hold state=%0d to=%0b want=1,%0b", bus.state, bus.timeout, m_to); end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_premature_rise();
        test_saturation();
        test_clr_collision();
        test_reset_mid();
        do_reset();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muller_c_monitor.md
Name: muller_c_monitor

Overview:
- Clocked observer placed directly downstream of the Muller C-element in the muller_c_proj user area.
- Synchronises the element's inputs A and B and its output C into the clock domain.
- Counts C rising and falling transitions and tracks the four-phase protocol with an FSM.
- Flags sticky protocol violations, such as C changing without input consensus, for readout over io_out / logic analyser.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range 2..4.
- CNT_W, 16, width of the rise and fall transition counters.
- TIMEOUT_CYC, 64, cycles allowed between input consensus and the C response; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a_async  in  1  C-element input A, asynchronous.
- b_async  in  1  C-element input B, asynchronous.
- c_async  in  1  C-element output C, asynchronous.
- clr  in  1  synchronous clear pulse.
- c_sync  out  1  synchronised C.
- rise_cnt  out  CNT_W  count of C 0->1 transitions.
- fall_cnt  out  CNT_W  count of C 1->0 transitions.
- state  out  2  current FSM state code.
- violation  out  1  sticky error flag.
- viol_code  out  2  code of the first violation.
- timeout  out  1  sticky timeout flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset and clock:
  - One clock, clk; reset is asynchronous and active-low, rst_n.
  - On reset, all synchroniser flops clear to 0, and every output clears to 0 (state = IDLE_LO = 2'b00).
- Synchronisers:
  - Each async input passes through SYNC_STAGES flops, giving a_s, b_s and c_s.
  - c_sync = c_s.
  - Latency: async change to c_sync is SYNC_STAGES clk edges.
- Edge detection:
  - c_q is c_s delayed one cycle.
  - rise = c_s & ~c_q; fall = ~c_s & c_q.
  - Counters and FSM update on the edge after rise/fall is asserted, i.e. SYNC_STAGES+1 cycles after the async change.
- Counters:
  - rise_cnt increments on rise; fall_cnt increments on fall.
  - Both saturate at all-ones; no wrap.
- Consensus window (tolerates one cycle of synchroniser skew):
  - hi_ok = (a_s & b_s) | (a_q & b_q), where a_q and b_q are a_s and b_s delayed one cycle.
  - lo_ok = (~a_s & ~b_s) | (~a_q & ~b_q).
- FSM state 00 IDLE_LO (C=0):
  - hi_ok & ~rise -> 01 ARMED_HI.
  - rise & hi_ok -> 10 IDLE_HI.
  - rise & ~hi_ok -> violation with code 01; go to IDLE_HI.
- FSM state 01 ARMED_HI:
  - rise -> IDLE_HI.
  - Consensus lost (~hi_ok) without a rise -> back to IDLE_LO; not an error.
- FSM state 10 IDLE_HI (C=1):
  - lo_ok & ~fall -> 11 ARMED_LO.
  - fall & lo_ok -> IDLE_LO.
  - fall & ~lo_ok -> violation with code 10; go to IDLE_LO.
- FSM state 11 ARMED_LO:
  - fall -> IDLE_LO.
  - Consensus lost (~lo_ok) -> IDLE_HI.
- Violation reporting:
  - violation is sticky.
  - viol_code latches only the first violation and holds until clr or reset.
  - Code 11 is reserved for timeout.
- clr:
  - Zeroes both counters, violation, viol_code and timeout.
  - Re-seeds state from c_s: IDLE_LO if c_s=0, else IDLE_HI.
  - If clr coincides with rise or fall, clr wins: the count stays 0 and the state is re-seeded from c_s.
- Reset mid-operation:
  - Asynchronous clear of all state.
  - After rst_n deasserts, the monitor needs SYNC_STAGES cycles before c_sync reflects the pin.
  - A C=1 that appears after reset counts as one rise. This is a documented artefact, not a violation, because a_s/b_s settle in the same cycles.

Optional Feature:
- Macro: MULLER_MON_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) runs while in ARMED_HI or ARMED_LO and clears on any other state.
  - On reaching TIMEOUT_CYC it sets sticky timeout and, if no earlier violation exists, sets violation with viol_code = 11.
  - The FSM stays in the armed state.
- When undefined:
  - No counter logic is present.
  - timeout is tied 0, and code 11 never occurs.

Decomposition:
- Package muller_c_pkg holds:
  - the state encoding constants ST_IDLE_LO, ST_ARMED_HI, ST_IDLE_HI, ST_ARMED_LO;
  - the violation codes VC_NONE, VC_RISE, VC_FALL, VC_TIMEOUT.
- One sub-module, muller_sync: a parameterised SYNC_STAGES flop chain with async active-low reset, instantiated three times.

Test Plan:
- Legal cycle:
  - Stimulus: A=B=1, then C=1 two cycles later; then A=B=0, then C=0.
  - Response: rise_cnt=1, fall_cnt=1, state sequence 00->01->10->11->00, violation=0.
- Premature rise:
  - Stimulus: A=1, B=0, C driven 1.
  - Response: violation=1, viol_code=01, rise_cnt=1, state=10.
- Saturation:
  - Stimulus: CNT_W=4, 20 legal full cycles.
  - Response: rise_cnt=fall_cnt=15; no violation.
- clr collision:
  - Stimulus: assert clr on the cycle rise is detected.
  - Response: rise_cnt=0, violation=0, state=10.
- Reset mid-operation:
  - Stimulus: pull rst_n low while in ARMED_HI with rise_cnt=3.
  - Response: all outputs read 0 immediately; after release with C=1 held, rise_cnt=1 after SYNC_STAGES+1 cycles.
- Timeout, with MULLER_MON_TIMEOUT_EN:
  - Stimulus: hold A=B=1 with C=0 for 70 cycles, TIMEOUT_CYC=64.
  - Response: timeout=1 and viol_code=11 at cycle 64 of ARMED_HI.
  - Without the macro, timeout stays 0.
